// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit_pkg
// Brief   : Function codes and decode helpers for the HI/LO multiply/divide unit
// Revision: 1.0
// ============================================================================
package mul_div_unit_pkg;

  localparam logic [5:0] c_FUN_MULT  = 6'b011000;
  localparam logic [5:0] c_FUN_MULTU = 6'b011001;
  localparam logic [5:0] c_FUN_DIV   = 6'b011010;
  localparam logic [5:0] c_FUN_DIVU  = 6'b011011;
  localparam logic [5:0] c_FUN_MTHI  = 6'b010001;
  localparam logic [5:0] c_FUN_MTLO  = 6'b010011;

  function automatic logic is_iter_funct(input logic [5:0] f);
    return (f == c_FUN_MULT) || (f == c_FUN_MULTU) ||
           (f == c_FUN_DIV)  || (f == c_FUN_DIVU);
  endfunction

  function automatic logic is_known_funct(input logic [5:0] f);
    return is_iter_funct(f) || (f == c_FUN_MTHI) || (f == c_FUN_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_step.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_step
// Brief   : One combinational shift-add multiply or restoring divide iteration
// Revision: 1.0
// ============================================================================
module mul_div_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN:0]  i_acc,
  input  logic [XLEN-1:0]  i_opnd,
  input  logic             i_is_div,
  output logic [2*XLEN:0]  o_acc
);

  logic [XLEN:0] w_mul_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  // Multiply: upper half (with carry) accumulates, multiplier drains from the LSB.
  // Divide: upper half is the partial remainder, quotient bits enter at the LSB.
  always_comb begin
    w_mul_sum = {i_acc[2*XLEN], i_acc[2*XLEN-1:XLEN]} +
                (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
    w_rem_sh  = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_diff    = w_rem_sh - {1'b0, i_opnd};
    if (i_is_div) begin
      if (!w_diff[XLEN]) begin
        o_acc = {1'b0, w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end else begin
        o_acc = {1'b0, w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      o_acc = {1'b0, w_mul_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit
// Brief   : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO
// Revision: 1.0
// ============================================================================
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [XLEN-1:0]  opA,
  input  logic [XLEN-1:0]  opB,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  hi,
  output logic [XLEN-1:0]  lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int CW = $clog2(XLEN + 1);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_count;
  logic [2*XLEN:0]   r_acc, w_acc_step;
  logic [XLEN-1:0]   r_opnd, r_orig_a, r_hi, r_lo;
  logic              r_is_div, r_neg_q, r_neg_r, r_div0, r_done;

  logic              w_issue, w_sgn, w_is_div_in, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_fix_hi, w_fix_lo;

  mul_div_step #(.XLEN(XLEN)) u_step (
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_is_div (r_is_div),
    .o_acc    (w_acc_step)
  );

  always_comb begin
    w_issue     = start && (r_state == S_IDLE) && is_iter_funct(funct);
    w_sgn       = (funct == c_FUN_MULT) || (funct == c_FUN_DIV);
    w_is_div_in = (funct == c_FUN_DIV) || (funct == c_FUN_DIVU);
    w_a_neg     = w_sgn && opA[XLEN-1];
    w_b_neg     = w_sgn && opB[XLEN-1];
    w_mag_a     = w_a_neg ? -opA : opA;
    w_mag_b     = w_b_neg ? -opB : opB;
  end

  // Sign correction; divide-by-zero bypasses it and returns the raw dividend.
  always_comb begin
    w_prod = r_neg_q ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
    w_quot = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    if (!r_is_div) begin
      w_fix_hi = w_prod[2*XLEN-1:XLEN];
      w_fix_lo = w_prod[XLEN-1:0];
    end else if (r_div0) begin
      w_fix_hi = r_orig_a;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quot;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_CALC;
      S_CALC:  if (r_count == CW'(XLEN - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_orig_a <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && funct == c_FUN_MTHI) begin
            r_hi <= opA;
          end else if (start && funct == c_FUN_MTLO) begin
            r_lo <= opA;
          end else if (w_issue) begin
            r_acc    <= {{(XLEN+1){1'b0}}, (w_is_div_in ? w_mag_a : w_mag_b)};
            r_opnd   <= w_is_div_in ? w_mag_b : w_mag_a;
            r_orig_a <= opA;
            r_is_div <= w_is_div_in;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= w_is_div_in && (opB == '0);
            r_count  <= '0;
          end
        end
        S_CALC: begin
          r_acc   <= w_acc_step;
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && start && (r_state == S_IDLE) && !is_known_funct(funct))
      $warning("%m: unsupported funct %b", funct);
  end
`endif

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Self-checking bench for mul_div_unit against an arithmetic model
// Revision: 1.0
// ============================================================================
module tb_mul_div_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'b0;
  logic [31:0] opA = 32'b0;
  logic [31:0] opB = 32'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions.
  function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (f)
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      F_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      F_DIVU: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
      F_DIV: begin
        if (b == 0) begin h = a; l = '1; end
        else begin
          p = 64'(sa / sb); l = p[31:0];
          p = 64'(sa % sb); h = p[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Cycle-level model: an issued mult/div completes 33 edges later.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_init = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end
    end else if (start) begin
      case (funct)
        F_MTHI: m_hi = opA;
        F_MTLO: m_lo = opA;
        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
          ref_op(funct, opA, opB, p_hi, p_lo);
          m_left = 33;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat = 0;
    int bc  = 0;
    @(negedge clk); start = 1'b1; funct = f; opA = a; opB = b;
    @(negedge clk); start = 1'b0;
    while (!done && lat < 60) begin
      if (busy) bc++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check({name, " latency"}, lat, 33);
    check({name, " busy_cycles"}, bc, 33);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 80) begin @(negedge clk); n++; end
    check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] h, l;
    logic [5:0] codes [6];
    bit seen;
    codes = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

    ref_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l);
    check("model multu hi", h, 32'hFFFF_FFFE);
    check("model multu lo", l, 32'h0000_0001);
    ref_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
    check("model div ovf hi", h, 32'h0);
    check("model div ovf lo", l, 32'h8000_0000);
    ref_op(F_DIV, 32'hFFFF_FFF9, 32'd2, h, l);
    check("model div neg hi", h, 32'hFFFF_FFFF);
    check("model div neg lo", l, 32'hFFFF_FFFD);

    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b0;

    run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*7", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 100/7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu by0", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div by0", F_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    @(negedge clk); start = 1'b1; funct = F_MULTU; opA = 32'd3; opB = 32'd4;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; funct = F_DIVU; opA = 32'd9; opB = 32'd3;
    @(negedge clk); start = 1'b0;
    wait_done();
    check("ignore hi", hi, 32'd0);
    check("ignore lo", lo, 32'd12);

    @(negedge clk); start = 1'b1; funct = F_MTHI; opA = 32'h1234;
    @(negedge clk); start = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi done", {31'b0, done}, 32'd0);
    check("mthi busy", {31'b0, busy}, 32'd0);

    start = 1'b1; funct = 6'b000000; opA = 32'hDEAD;
    @(negedge clk); start = 1'b0;
    check("bad funct busy", {31'b0, busy}, 32'd0);
    check("bad funct hi", hi, 32'h1234);

    @(negedge clk); start = 1'b1; funct = F_DIVU; opA = 32'd1000; opB = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    check("abort no done", {31'b0, seen}, 32'd0);
    run_op("multu 6*7", F_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      funct = codes[$urandom_range(0, 5)];
      opA   = pick();
      opB   = pick();
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk); start = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit owning the HI/LO architectural registers. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations and MTHI/MTLO as single-cycle writes. It sits beside the combinational ALU in the execute stage. The pipeline stalls on `busy` and reads `hi`/`lo` directly for MFHI/MFLO.

Parameters:
XLEN, 32, operand and HI/LO width; the iteration count equals XLEN.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  issue request; sampled only when busy=0
funct  input  6  `FUN_MULT/`FUN_MULTU/`FUN_DIV/`FUN_DIVU/`FUN_MTHI/`FUN_MTLO
opA  input  XLEN  rs value (multiplicand/dividend; MTHI/MTLO data)
opB  input  XLEN  rt value (multiplier/divisor)
busy  output  1  iterative operation in flight
done  output  1  one-cycle pulse: hi/lo just updated by a mult/div
hi  output  XLEN  HI register
lo  output  XLEN  LO register

Behaviour:
- Reset is synchronous and active-high. At reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation and discards partial results.
- States:
  - IDLE: accepts start.
  - CALC: 32 iterations, one per clock.
  - FIX: sign correction and HI/LO write, then back to IDLE.
- `busy` = (state != IDLE), from registered state. `done` is a registered pulse.
- Issue: start=1 and busy=0 at edge N.
  - MTHI/MTLO: hi (or lo) = opA after edge N. No busy, no done.
  - MULT*/DIV*: operands latched. Signed ops store magnitudes plus result-sign flags. state=CALC, count=0.
- CALC, edges N+1..N+32: one iteration per edge; count increments.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract; quotient bit = no-borrow.
  - After the 32nd iteration, state=FIX.
- FIX, edge N+33:
  - Signed ops: negate the product if signs differ. Quotient is negated if signs differ; remainder takes the dividend's sign.
  - hi = product[63:32] or remainder; lo = product[31:0] or quotient. done=1 for exactly the cycle after edge N+33. state=IDLE.
- Latency: every mult/div takes 33 cycles from issue to done. busy is high for cycles N+1..N+33 (33 cycles). A new start is accepted in the done cycle.
- start while busy=1 is ignored completely; the pipeline must hold the instruction.
- start with an unlisted funct: ignored, no state change. Simulation emits $warning (`%m` plus funct in binary), matching existing datapath warnings.
- hi/lo hold their values during CALC. Partial results never appear on the ports.
- Divide by zero (opB=0, signed or unsigned): the full 33-cycle latency still applies. Forced result hi=opA (original, unsigned view), lo=32'hFFFFFFFF. No sign fix.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: the natural algorithm result is lo=0x80000000, hi=0. No trap.
- Arithmetic is modulo 2^XLEN on each half. The multiply accumulator is 2*XLEN+1 bits internally to absorb the carry.

Decomposition:
- Add `FUN_MULT(6'b011000), `FUN_MULTU(6'b011001), `FUN_DIV(6'b011010), `FUN_DIVU(6'b011011), `FUN_MTHI(6'b010001), `FUN_MTLO(6'b010011) to ISA.v, alongside the existing FUN_ codes.
- The state encoding (IDLE/CALC/FIX) stays local to the module.
- One natural sub-module: mul_div_step. It is combinational and computes one multiply or divide iteration from (accumulator, operand, isDiv). It keeps the FSM file focused on control and lets the step be unit-tested exhaustively at small XLEN.

Test Plan:
- MULTU opA=0xFFFFFFFF opB=0xFFFFFFFF -> done exactly 33 cycles after issue; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT opA=0xFFFFFFFD(-3) opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21).
- DIV opA=0xFFFFFFF9(-7) opB=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU opA=100 opB=7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU opA=5 opB=0 -> after 33 cycles hi=5, lo=0xFFFFFFFF. DIV opA=0xFFFFFFFB opB=0 -> hi=0xFFFFFFFB, lo=0xFFFFFFFF.
- Issue MULTU 3*4, then pulse start with DIVU 9/3 at cycle 5 -> second request ignored; result hi=0, lo=12. Issue MTHI opA=0x1234 while idle -> hi=0x1234 next cycle, done stays 0.
- Issue DIVU, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0, done never pulses. A following MULTU 6*7 gives lo=42 in 33 cycles.
